// File: rtl/fifo_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// fifo_pkg : shared FIFO types and Gray-code helpers        rev 1.1
// ----------------------------------------------------------------------------
package fifo_pkg;

  localparam int GRAY_MAX_W = 32;

  typedef struct packed {
    int unsigned data_w;
    int unsigned depth;
  } fifo_cfg_t;

  localparam fifo_cfg_t c_fifo_cfg_default = '{data_w: 32, depth: 32};

  // Callers zero-extend narrower vectors; leading zeros leave the low bits exact.
  function automatic logic [GRAY_MAX_W-1:0] bin2gray(input logic [GRAY_MAX_W-1:0] bin);
    return bin ^ (bin >> 1);
  endfunction

  function automatic logic [GRAY_MAX_W-1:0] gray2bin(input logic [GRAY_MAX_W-1:0] gray);
    logic [GRAY_MAX_W-1:0] bin;
    bin[GRAY_MAX_W-1] = gray[GRAY_MAX_W-1];
    for (int i = GRAY_MAX_W - 2; i >= 0; i--) begin
      bin[i] = bin[i+1] ^ gray[i];
    end
    return bin;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fifo_gray2bin.sv
`default_nettype none
// ----------------------------------------------------------------------------
// fifo_gray2bin : combinational Gray-to-binary pointer decode  rev 1.1
// ----------------------------------------------------------------------------
module fifo_gray2bin
  import fifo_pkg::*;
#(
  parameter int PTR_W = 6
) (
  input  logic [PTR_W-1:0] gray,
  output logic [PTR_W-1:0] bin
);

  for (genvar i = 0; i < PTR_W; i++) begin : g_bit
    assign bin[i] = ^gray[PTR_W-1:i];
  end

endmodule
`default_nettype wire

// File: rtl/fifo_wr_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// fifo_wr_ctrl : async FIFO write-domain pointer, flag and RAM-port control
// rev 1.1
// ----------------------------------------------------------------------------
module fifo_wr_ctrl
  import fifo_pkg::*;
#(
  parameter  int DATA_W = 32,
  parameter  int DEPTH  = 32,
  localparam int ADDR_W = $clog2(DEPTH),
  localparam int PTR_W  = ADDR_W + 1
) (
  input  logic              wclk,
  input  logic              hw_rst_n,
  input  logic              sw_rst,
  input  logic              write_enable,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] afull_value,
  input  logic              ovf_clr,
  input  logic [PTR_W-1:0]  rptr_gray_sync,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_waddr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [PTR_W-1:0]  wptr_gray,
  output logic              wfull,
  output logic              wr_almost_ful,
  output logic              overflow,
  output logic [PTR_W-1:0]  fifo_write_count,
  output logic [PTR_W-1:0]  wr_level
);

  logic [PTR_W-1:0] r_wbin;
  logic [PTR_W-1:0] r_wgray;
  logic [PTR_W-1:0] r_level;
  logic [PTR_W-1:0] r_count;
  logic             r_wfull;
  logic             r_afull;
  logic             r_ovf;

  logic             w_push;
  logic [PTR_W-1:0] w_push_ext;
  logic [PTR_W-1:0] w_wbin_nxt;
  logic [PTR_W-1:0] w_wgray_nxt;
  logic [PTR_W-1:0] w_rbin;
  logic [PTR_W-1:0] w_level_nxt;
  logic [PTR_W-1:0] w_rgray_full;
  logic             w_full_nxt;
  logic             w_afull_nxt;

  fifo_gray2bin #(.PTR_W(PTR_W)) u_rptr_dec (
    .gray (rptr_gray_sync),
    .bin  (w_rbin)
  );

  // hw_rst_n keeps the strobe low for the whole time the block is held in reset.
  assign w_push     = write_enable & ~r_wfull & ~sw_rst & hw_rst_n;
  assign w_push_ext = {{(PTR_W-1){1'b0}}, w_push};

  assign w_wbin_nxt  = r_wbin + w_push_ext;
  assign w_wgray_nxt = PTR_W'(bin2gray(GRAY_MAX_W'(w_wbin_nxt)));
  assign w_level_nxt = w_wbin_nxt - w_rbin;

  // Full when the write pointer is one lap ahead: top two Gray bits inverted, rest equal.
  assign w_rgray_full = {~rptr_gray_sync[PTR_W-1:PTR_W-2], rptr_gray_sync[PTR_W-3:0]};
  assign w_full_nxt   = (w_wgray_nxt == w_rgray_full);
  assign w_afull_nxt  = (afull_value != '0) && (w_level_nxt >= {1'b0, afull_value});

  always_ff @(posedge wclk or negedge hw_rst_n) begin
    if (!hw_rst_n) begin
      r_wbin  <= '0;
      r_wgray <= '0;
      r_level <= '0;
      r_count <= '0;
      r_wfull <= 1'b0;
      r_afull <= 1'b0;
      r_ovf   <= 1'b0;
    end else if (sw_rst) begin
      r_wbin  <= '0;
      r_wgray <= '0;
      r_level <= '0;
      r_count <= '0;
      r_wfull <= 1'b0;
      r_afull <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      r_wbin  <= w_wbin_nxt;
      r_wgray <= w_wgray_nxt;
      r_level <= w_level_nxt;
      r_count <= r_count + w_push_ext;
      r_wfull <= w_full_nxt;
      r_afull <= w_afull_nxt;
      // A dropped write outranks a same-cycle clear so the event is never lost.
      if (write_enable && r_wfull) begin
        r_ovf <= 1'b1;
      end else if (ovf_clr) begin
        r_ovf <= 1'b0;
      end
    end
  end

  assign mem_we           = w_push;
  assign mem_waddr        = r_wbin[ADDR_W-1:0];
  assign mem_wdata        = wdata;
  assign wptr_gray        = r_wgray;
  assign wfull            = r_wfull;
  assign wr_almost_ful    = r_afull;
  assign overflow         = r_ovf;
  assign fifo_write_count = r_count;
  assign wr_level         = r_level;

endmodule
`default_nettype wire

// File: tb/tb_fifo_wr_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_fifo_wr_ctrl : self-checking bench with a count-based reference model
// rev 1.1
// ----------------------------------------------------------------------------
module tb_fifo_wr_ctrl;

  localparam int DW = 32;
  localparam int D  = 32;
  localparam int AW = 5;
  localparam int PW = 6;

  logic          wclk = 1'b0;
  logic          hw_rst_n = 1'b0;
  logic          sw_rst = 1'b0;
  logic          write_enable = 1'b0;
  logic          ovf_clr = 1'b0;
  logic [DW-1:0] wdata = '0;
  logic [AW-1:0] afull_value = '0;
  logic [PW-1:0] rptr_gray_sync = '0;
  logic          mem_we, wfull, wr_almost_ful, overflow;
  logic [AW-1:0] mem_waddr;
  logic [DW-1:0] mem_wdata;
  logic [PW-1:0] wptr_gray, fifo_write_count, wr_level;

  // Small (4 x 8) and large (256 x 64) instances for the parameter sweep.
  logic       s_we = 1'b0;
  logic [7:0] s_wdata = '0;
  logic       s_mem_we, s_wfull, s_afull, s_ovf;
  logic [1:0] s_mem_waddr;
  logic [7:0] s_mem_wdata;
  logic [2:0] s_wptr, s_cnt, s_lvl;

  logic        l_we = 1'b0;
  logic [63:0] l_wdata = '0;
  logic        l_mem_we, l_wfull, l_afull, l_ovf;
  logic [7:0]  l_mem_waddr;
  logic [63:0] l_mem_wdata;
  logic [8:0]  l_wptr, l_cnt, l_lvl;

  int checks = 0;
  int failures = 0;

  // Reference model: total accepted writes and total reads, unbounded integers.
  int m_w, m_r, m_level;
  bit m_full, m_afull, m_ovf;

  always #5 wclk = ~wclk;

  fifo_wr_ctrl #(.DATA_W(DW), .DEPTH(D)) dut (
    .wclk(wclk), .hw_rst_n(hw_rst_n), .sw_rst(sw_rst), .write_enable(write_enable),
    .wdata(wdata), .afull_value(afull_value), .ovf_clr(ovf_clr),
    .rptr_gray_sync(rptr_gray_sync), .mem_we(mem_we), .mem_waddr(mem_waddr),
    .mem_wdata(mem_wdata), .wptr_gray(wptr_gray), .wfull(wfull),
    .wr_almost_ful(wr_almost_ful), .overflow(overflow),
    .fifo_write_count(fifo_write_count), .wr_level(wr_level)
  );

  fifo_wr_ctrl #(.DATA_W(8), .DEPTH(4)) dut_s (
    .wclk(wclk), .hw_rst_n(hw_rst_n), .sw_rst(1'b0), .write_enable(s_we),
    .wdata(s_wdata), .afull_value(2'd0), .ovf_clr(1'b0), .rptr_gray_sync(3'd0),
    .mem_we(s_mem_we), .mem_waddr(s_mem_waddr), .mem_wdata(s_mem_wdata),
    .wptr_gray(s_wptr), .wfull(s_wfull), .wr_almost_ful(s_afull), .overflow(s_ovf),
    .fifo_write_count(s_cnt), .wr_level(s_lvl)
  );

  fifo_wr_ctrl #(.DATA_W(64), .DEPTH(256)) dut_l (
    .wclk(wclk), .hw_rst_n(hw_rst_n), .sw_rst(1'b0), .write_enable(l_we),
    .wdata(l_wdata), .afull_value(8'd0), .ovf_clr(1'b0), .rptr_gray_sync(9'd0),
    .mem_we(l_mem_we), .mem_waddr(l_mem_waddr), .mem_wdata(l_mem_wdata),
    .wptr_gray(l_wptr), .wfull(l_wfull), .wr_almost_ful(l_afull), .overflow(l_ovf),
    .fifo_write_count(l_cnt), .wr_level(l_lvl)
  );

  function automatic logic [PW-1:0] g6(input int n);
    logic [PW-1:0] b;
    b = PW'(n % 64);
    return b ^ (b >> 1);
  endfunction

  task automatic model_clear();
    m_w = 0; m_r = 0; m_level = 0; m_full = 0; m_afull = 0; m_ovf = 0;
  endtask

  task automatic drive(input bit we, input bit clr, input bit sw);
    write_enable   = we;
    ovf_clr        = clr;
    sw_rst         = sw;
    wdata          = $urandom;
    rptr_gray_sync = g6(m_r);
    #1;
  endtask

  // Advance one clock and move the model to the state the spec prescribes.
  task automatic tick();
    bit we_s, clr_s, sw_s, push;
    int af;
    we_s  = write_enable;
    clr_s = ovf_clr;
    sw_s  = sw_rst;
    af    = int'(afull_value);
    push  = we_s && !m_full && !sw_s;
    @(posedge wclk);
    if (sw_s) begin
      model_clear();
    end else begin
      if (we_s && m_full) m_ovf = 1;
      else if (clr_s)     m_ovf = 0;
      if (push) m_w++;
      m_level = (m_w - m_r) % 64;
      m_full  = (m_level == D);
      m_afull = (af != 0) && (m_level >= af);
    end
    #1;
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if ({mem_we, wfull, wr_almost_ful, overflow, wptr_gray, fifo_write_count, wr_level} !== '0) begin
      failures++;
      $display("FAIL reset_state got we=%b full=%b af=%b ovf=%b gray=%h cnt=%0d lvl=%0d expected all 0",
               mem_we, wfull, wr_almost_ful, overflow, wptr_gray, fifo_write_count, wr_level);
    end
    model_clear();
    @(negedge wclk);
    hw_rst_n = 1'b1;
    @(posedge wclk); #1;
    for (int i = 0; i < 5; i++) begin
      drive(1, 0, 0);
      tick();
    end
    // Assert reset between edges with a write still requested.
    #2;
    hw_rst_n = 1'b0;
    #1;
    checks++;
    if ({mem_we, mem_waddr, wfull, overflow, wptr_gray, fifo_write_count, wr_level} !== '0) begin
      failures++;
      $display("FAIL async_reset got we=%b addr=%0d full=%b gray=%h cnt=%0d lvl=%0d expected all 0",
               mem_we, mem_waddr, wfull, wptr_gray, fifo_write_count, wr_level);
    end
    model_clear();
    write_enable = 1'b0;
    @(negedge wclk);
    hw_rst_n = 1'b1;
    drive(1, 0, 0);
    tick();
    checks++;
    if (wr_level !== 6'd1 || wptr_gray !== 6'h01 || fifo_write_count !== 6'd1) begin
      failures++;
      $display("FAIL first_write got lvl=%0d gray=%h cnt=%0d expected lvl=1 gray=01 cnt=1",
               wr_level, wptr_gray, fifo_write_count);
    end
  endtask

  task automatic soft_reset();
    drive(0, 0, 1);
    tick();
    sw_rst = 1'b0;
  endtask

  task automatic test_fill();
    soft_reset();
    afull_value = '0;
    for (int i = 0; i < D; i++) begin
      drive(1, 0, 0);
      checks++;
      if (mem_we !== 1'b1 || mem_waddr !== AW'(m_w % D) || mem_wdata !== wdata) begin
        failures++;
        $display("FAIL fill_port%0d got we=%b addr=%0d data=%h expected we=1 addr=%0d data=%h",
                 i, mem_we, mem_waddr, mem_wdata, m_w % D, wdata);
      end
      tick();
      checks++;
      if (wfull !== (i == D - 1) || wr_level !== PW'(m_level)) begin
        failures++;
        $display("FAIL fill_flags%0d got full=%b lvl=%0d expected full=%b lvl=%0d",
                 i, wfull, wr_level, i == D - 1, m_level);
      end
    end
    checks++;
    if (wr_level !== 6'd32 || fifo_write_count !== 6'd32) begin
      failures++;
      $display("FAIL fill_level got lvl=%0d cnt=%0d expected 32 32", wr_level, fifo_write_count);
    end
    drive(1, 0, 0);
    checks++;
    if (mem_we !== 1'b0) begin
      failures++;
      $display("FAIL overflow_drop got we=%b expected 0", mem_we);
    end
    tick();
    checks++;
    if (overflow !== 1'b1 || wr_level !== 6'd32 || fifo_write_count !== 6'd32) begin
      failures++;
      $display("FAIL overflow_set got ovf=%b lvl=%0d cnt=%0d expected 1 32 32",
               overflow, wr_level, fifo_write_count);
    end
    drive(0, 1, 0);
    tick();
    checks++;
    if (overflow !== 1'b0) begin
      failures++;
      $display("FAIL overflow_clear got ovf=%b expected 0", overflow);
    end
  endtask

  task automatic test_almost_full();
    soft_reset();
    afull_value = 5'd28;
    for (int i = 1; i <= D; i++) begin
      drive(1, 0, 0);
      tick();
      checks++;
      if (wr_almost_ful !== (i >= 28) || wr_almost_ful !== m_afull) begin
        failures++;
        $display("FAIL afull_28_lvl%0d got af=%b expected %b", i, wr_almost_ful, i >= 28);
      end
    end
    soft_reset();
    afull_value = '0;
    for (int i = 1; i <= D; i++) begin
      drive(1, 0, 0);
      tick();
      checks++;
      if (wr_almost_ful !== 1'b0) begin
        failures++;
        $display("FAIL afull_off_lvl%0d got af=%b expected 0", i, wr_almost_ful);
      end
    end
  endtask

  task automatic test_wrap();
    soft_reset();
    for (int i = 0; i < D; i++) begin
      drive(1, 0, 0);
      tick();
    end
    m_r = 32;
    drive(0, 0, 0);
    tick();
    checks++;
    if (wfull !== 1'b0 || wr_level !== 6'd0) begin
      failures++;
      $display("FAIL wrap_drain got full=%b lvl=%0d expected 0 0", wfull, wr_level);
    end
    for (int i = 0; i < D; i++) begin
      drive(1, 0, 0);
      checks++;
      if (mem_we !== 1'b1 || mem_waddr !== AW'(i)) begin
        failures++;
        $display("FAIL wrap_addr%0d got we=%b addr=%0d expected 1 %0d", i, mem_we, mem_waddr, i);
      end
      tick();
    end
    checks++;
    if (wfull !== 1'b1 || wptr_gray !== 6'h00 || fifo_write_count !== 6'd0 || wr_level !== 6'd32) begin
      failures++;
      $display("FAIL wrap_end got full=%b gray=%h cnt=%0d lvl=%0d expected 1 00 0 32",
               wfull, wptr_gray, fifo_write_count, wr_level);
    end
  endtask

  task automatic test_simultaneous();
    soft_reset();
    for (int i = 0; i < D; i++) begin
      drive(1, 0, 0);
      tick();
    end
    drive(1, 1, 0);
    tick();
    checks++;
    if (overflow !== 1'b1 || overflow !== m_ovf) begin
      failures++;
      $display("FAIL set_beats_clear got ovf=%b expected 1", overflow);
    end
    drive(1, 0, 1);
    checks++;
    if (mem_we !== 1'b0) begin
      failures++;
      $display("FAIL swrst_we got we=%b expected 0", mem_we);
    end
    tick();
    sw_rst = 1'b0;
    checks++;
    if ({wfull, wr_almost_ful, overflow, wptr_gray, fifo_write_count, wr_level} !== '0) begin
      failures++;
      $display("FAIL swrst_clear got full=%b af=%b ovf=%b gray=%h cnt=%0d lvl=%0d expected all 0",
               wfull, wr_almost_ful, overflow, wptr_gray, fifo_write_count, wr_level);
    end
  endtask

  task automatic test_random();
    bit we, clr;
    soft_reset();
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 7) == 0) afull_value = AW'($urandom_range(0, 31));
      if (m_r < m_w && $urandom_range(0, 2) == 0) m_r += $urandom_range(1, m_w - m_r);
      we  = ($urandom_range(0, 3) != 0);
      clr = ($urandom_range(0, 7) == 0);
      drive(we, clr, 0);
      checks++;
      if (mem_we !== (we && !m_full) || mem_waddr !== AW'(m_w % D) || mem_wdata !== wdata) begin
        failures++;
        $display("FAIL rand_port%0d got we=%b addr=%0d expected we=%b addr=%0d",
                 n, mem_we, mem_waddr, we && !m_full, m_w % D);
      end
      tick();
      checks++;
      if (wr_level !== PW'(m_level) || wfull !== m_full || wr_almost_ful !== m_afull ||
          overflow !== m_ovf || wptr_gray !== g6(m_w) || fifo_write_count !== PW'(m_w % 64)) begin
        failures++;
        $display("FAIL rand_state%0d got lvl=%0d full=%b af=%b ovf=%b gray=%h cnt=%0d expected lvl=%0d full=%b af=%b ovf=%b gray=%h cnt=%0d",
                 n, wr_level, wfull, wr_almost_ful, overflow, wptr_gray, fifo_write_count,
                 m_level, m_full, m_afull, m_ovf, g6(m_w), m_w % 64);
      end
    end
  endtask

  task automatic test_param_small();
    for (int i = 0; i < 4; i++) begin
      s_we = 1'b1;
      s_wdata = 8'($urandom);
      #1;
      checks++;
      if (s_mem_we !== 1'b1 || s_mem_waddr !== 2'(i) || s_mem_wdata !== s_wdata) begin
        failures++;
        $display("FAIL small_port%0d got we=%b addr=%0d expected 1 %0d", i, s_mem_we, s_mem_waddr, i);
      end
      @(posedge wclk); #1;
      checks++;
      if (s_wfull !== (i == 3) || s_lvl !== 3'(i + 1)) begin
        failures++;
        $display("FAIL small_fill%0d got full=%b lvl=%0d expected %b %0d", i, s_wfull, s_lvl, i == 3, i + 1);
      end
    end
    #1;
    checks++;
    if (s_mem_we !== 1'b0 || s_cnt !== 3'd4) begin
      failures++;
      $display("FAIL small_full got we=%b cnt=%0d expected 0 4", s_mem_we, s_cnt);
    end
    @(posedge wclk); #1;
    s_we = 1'b0;
    checks++;
    if (s_ovf !== 1'b1 || s_lvl !== 3'd4) begin
      failures++;
      $display("FAIL small_ovf got ovf=%b lvl=%0d expected 1 4", s_ovf, s_lvl);
    end
  endtask

  task automatic test_param_large();
    for (int i = 0; i < 256; i++) begin
      l_we = 1'b1;
      l_wdata = {$urandom, $urandom};
      #1;
      checks++;
      if (l_mem_we !== 1'b1 || l_mem_waddr !== 8'(i) || l_mem_wdata !== l_wdata) begin
        failures++;
        $display("FAIL large_port%0d got we=%b addr=%0d expected 1 %0d", i, l_mem_we, l_mem_waddr, i);
      end
      @(posedge wclk); #1;
      checks++;
      if (l_wfull !== (i == 255) || l_lvl !== 9'(i + 1)) begin
        failures++;
        $display("FAIL large_fill%0d got full=%b lvl=%0d expected %b %0d", i, l_wfull, l_lvl, i == 255, i + 1);
      end
    end
    #1;
    checks++;
    if (l_mem_we !== 1'b0 || l_cnt !== 9'd256) begin
      failures++;
      $display("FAIL large_full got we=%b cnt=%0d expected 0 256", l_mem_we, l_cnt);
    end
    @(posedge wclk); #1;
    l_we = 1'b0;
    checks++;
    if (l_ovf !== 1'b1 || l_lvl !== 9'd256) begin
      failures++;
      $display("FAIL large_ovf got ovf=%b lvl=%0d expected 1 256", l_ovf, l_lvl);
    end
  endtask

  initial begin
    model_clear();
    test_reset();
    test_fill();
    test_almost_full();
    test_wrap();
    test_simultaneous();
    test_random();
    test_param_small();
    test_param_large();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
